// File: rtl/fpu_host_queue.sv
// rtl/fpu_host_queue.sv - host register front end with command/result FIFOs feeding an FPU core
// A dispatcher pops commands, runs them one at a time through the core, and queues the results.
module fpu_host_queue #(
   parameter int DW     = 8,
   parameter int QDEPTH = 4,
   parameter int OPW    = 4
) (
   input  logic           clk,
   input  logic           arst,
   input  logic [DW-1:0]  databus_in,
   output logic [DW-1:0]  databus_out,
   input  logic [3:0]     addr,
   input  logic           cs,
   input  logic           rd,
   input  logic           wr,
   input  logic           end_ack,
   output logic           cmd_end,
   output logic           busy,
   output logic [31:0]    core_a,
   output logic [31:0]    core_b,
   output logic [OPW-1:0] core_op,
   output logic           core_start,
   input  logic           core_done,
   input  logic [31:0]    core_result
);
   localparam int NB = 32 / DW;
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = 64 + OPW;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;
   state_t state, state_n;

   logic           wr_q, ack_q;
   logic [31:0]    stage_a, stage_b;
   logic [OPW-1:0] stage_op;
   logic           overflow;

   logic [CW-1:0]  cmd_mem [QDEPTH];
   logic [AW:0]    cmd_wp, cmd_rp;
   logic [31:0]    res_mem [QDEPTH];
   logic [AW:0]    res_wp, res_rp;
   logic [31:0]    res_cap;
   logic [31:0]    core_a_r, core_b_r;
   logic [OPW-1:0] core_op_r;

   logic commit, push_req, flush, ctrl_pop, ack_rise;
   logic cmd_full, cmd_empty, res_full, res_empty;
   logic cmd_push, cmd_pop, res_push, res_pop;
   logic [31:0]    res_head;
   logic [DW-1:0]  status;

   // Exactly one commit per wr-low pulse: the first cycle wr is seen low.
   assign commit   = !cs && !wr && wr_q;
   assign push_req = commit && (addr == 4'd9);
   assign flush    = commit && (addr == 4'd14) && databus_in[1];
   assign ctrl_pop = commit && (addr == 4'd14) && databus_in[0];
   assign ack_rise = end_ack && !ack_q;

   assign cmd_empty = (cmd_wp == cmd_rp);
   assign cmd_full  = (cmd_wp[AW] != cmd_rp[AW]) && (cmd_wp[AW-1:0] == cmd_rp[AW-1:0]);
   assign res_empty = (res_wp == res_rp);
   assign res_full  = (res_wp[AW] != res_rp[AW]) && (res_wp[AW-1:0] == res_rp[AW-1:0]);

   assign cmd_push = push_req && !cmd_full && !flush;
   assign cmd_pop  = (state == ISSUE) && !cmd_empty;
   assign res_push = (state == STORE) && !res_full;
   assign res_pop  = (ack_rise || ctrl_pop) && !res_empty;
   assign res_head = res_mem[res_rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (arst) begin
         wr_q     <= 1'b1;
         ack_q    <= 1'b0;
         stage_a  <= '0;
         stage_b  <= '0;
         stage_op <= '0;
         overflow <= 1'b0;
      end else begin
         wr_q  <= wr;
         ack_q <= end_ack;
         if (commit) begin
            for (int k = 0; k < NB; k++) begin
               if (addr == 4'(k))     stage_a[k*DW +: DW] <= databus_in;
               if (addr == 4'(4 + k)) stage_b[k*DW +: DW] <= databus_in;
            end
            if (addr == 4'd8) stage_op <= databus_in[OPW-1:0];
         end
         if (flush)
            overflow <= 1'b0;
         else if (push_req && cmd_full)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cmd_wp[AW-1:0]] <= {stage_a, stage_b, stage_op};
      if (res_push) res_mem[res_wp[AW-1:0]] <= res_cap;
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         cmd_wp <= '0;
         cmd_rp <= '0;
         res_wp <= '0;
         res_rp <= '0;
      end else begin
         // Flush wins over a same-cycle dispatch pop; the issued command is already latched.
         if (flush) begin
            cmd_rp <= cmd_wp;
         end else begin
            if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
            if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
         end
         if (res_push) res_wp <= res_wp + 1'b1;
         if (res_pop)  res_rp <= res_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state     <= IDLE;
         core_a_r  <= '0;
         core_b_r  <= '0;
         core_op_r <= '0;
         res_cap   <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n == ISSUE)
            {core_a_r, core_b_r, core_op_r} <= cmd_mem[cmd_rp[AW-1:0]];
         if (state == WAIT && core_done)
            res_cap <= core_result;
      end
   end

   always_comb begin
      state_n    = state;
      core_start = 1'b0;
      case (state)
         IDLE:  if (!cmd_empty && !res_full) state_n = ISSUE;
         ISSUE: begin
            core_start = 1'b1;
            state_n    = WAIT;
         end
         WAIT:  if (core_done) state_n = STORE;
         STORE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign core_a  = core_a_r;
   assign core_b  = core_b_r;
   assign core_op = core_op_r;
   assign cmd_end = !res_empty;
   assign busy    = !cmd_empty || (state != IDLE);

   always_comb begin
      status      = '0;
      status[4:0] = {busy, overflow, res_empty, cmd_empty, cmd_full};
   end

   always_comb begin
      databus_out = '0;
      if (!cs && !rd) begin
         if (addr == 4'd13) databus_out = status;
         for (int k = 0; k < NB; k++)
            if (addr == 4'(9 + k) && !res_empty) databus_out = res_head[k*DW +: DW];
      end
   end
endmodule
